gpr_wb_arbiter: RTL and testbench

//  Shares the GPR file's single write port between NUM_SRC writeback requesters (src 0 = ALU, src 1 = LSU).

---
 rtl/gpr_pkg.sv | 21 ++
 rtl/gpr_wb_fifo.sv | 59 +++++
 rtl/gpr_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared GPR geometry and writeback request type used by the writeback arbiter and its FIFOs.
`ifndef GPR_BITS
`define GPR_BITS 32
`endif
`ifndef GPR_ID_BITS
`define GPR_ID_BITS 5
`endif

package gpr_pkg;
  localparam int GPR_BITS    = `GPR_BITS;
  localparam int GPR_ID_BITS = `GPR_ID_BITS;
  localparam int GPR_NUM     = 1 << GPR_ID_BITS;

  typedef logic [GPR_ID_BITS-1:0] gpr_id_t;
  typedef logic [GPR_BITS-1:0]    gpr_val_t;

  typedef struct packed {
    gpr_id_t  id;
    gpr_val_t val;
  } wb_req_t;
endpackage

// File: rtl/gpr_wb_fifo.sv
// Per-source writeback FIFO; exposes head, full/empty and every slot's valid/id for hazard lookup.
module gpr_wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_req_t                      push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output wb_req_t                      head,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH*GPR_ID_BITS-1:0] ent_id
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [DEPTH-1:0] valid_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-slot valid bits make full/empty a lookup; push only when !full and pop only when !empty keeps slots disjoint.
  assign full  = valid_reg[wr_ptr_reg];
  assign empty = !valid_reg[rd_ptr_reg];
  assign head  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      valid_reg  <= '0;
    end else begin
      if (push) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg            <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    assign ent_valid[gi]                          = valid_reg[gi];
    assign ent_id[gi*GPR_ID_BITS +: GPR_ID_BITS]  = mem[gi].id;
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates per-source writeback FIFOs onto the single GPR write port and answers pending-write queries.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise lowest source index wins.
`ifndef GPR_BITS
`define GPR_BITS 32
`endif
`ifndef GPR_ID_BITS
`define GPR_ID_BITS 5
`endif

module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC*`GPR_ID_BITS-1:0] src_id,
  input  logic [NUM_SRC*`GPR_BITS-1:0]    src_val,
  output logic                            gpr_we,
  output logic [`GPR_ID_BITS-1:0]         gpr_write_id,
  output logic [`GPR_BITS-1:0]            gpr_write_val,
  input  logic [`GPR_ID_BITS-1:0]         pend_query_id,
  output logic                            pend_hit
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NENT  = NUM_SRC * FIFO_DEPTH;

  logic [NUM_SRC-1:0]         full;
  logic [NUM_SRC-1:0]         empty;
  logic [NUM_SRC-1:0]         push;
  logic [NUM_SRC-1:0]         pop;
  wb_req_t                    head [NUM_SRC];
  logic [NENT-1:0]            ent_valid;
  logic [NENT*GPR_ID_BITS-1:0] ent_id;
  logic [NENT-1:0]            ent_hit;
  logic                       grant_any;
  logic [SRC_W-1:0]           grant_idx;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    wb_req_t push_data;
    assign src_ready[gi] = !rst && !full[gi];
    // Writes to x0 are acknowledged but dropped before queuing.
    assign push[gi]      = src_valid[gi] && src_ready[gi] &&
                           (src_id[gi*GPR_ID_BITS +: GPR_ID_BITS] != '0);
    assign push_data     = '{id: src_id[gi*GPR_ID_BITS +: GPR_ID_BITS],
                             val: src_val[gi*GPR_BITS +: GPR_BITS]};

    gpr_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[gi]),
      .push_data (push_data),
      .pop       (pop[gi]),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .head      (head[gi]),
      .ent_valid (ent_valid[gi*FIFO_DEPTH +: FIFO_DEPTH]),
      .ent_id    (ent_id[gi*FIFO_DEPTH*GPR_ID_BITS +: FIFO_DEPTH*GPR_ID_BITS])
    );
  end

`ifdef WB_ARB_RR_EN
  logic [SRC_W-1:0] ptr_reg;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_any && !empty[SRC_W'((int'(ptr_reg) + k) % NUM_SRC)]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'((int'(ptr_reg) + k) % NUM_SRC);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      ptr_reg <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_any && !empty[k]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(k);
      end
    end
  end
`endif

  always_comb begin
    pop = '0;
    if (grant_any) pop[grant_idx] = 1'b1;
  end

  // Id/val hold their last value when idle; only gpr_we returns to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_we        <= 1'b0;
      gpr_write_id  <= '0;
      gpr_write_val <= '0;
    end else if (grant_any) begin
      gpr_we        <= 1'b1;
      gpr_write_id  <= head[grant_idx].id;
      gpr_write_val <= head[grant_idx].val;
    end else begin
      gpr_we        <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NENT; gi++) begin : g_hit
    assign ent_hit[gi] = ent_valid[gi] &&
                         (ent_id[gi*GPR_ID_BITS +: GPR_ID_BITS] == pend_query_id);
  end

  assign pend_hit = (pend_query_id != '0) &&
                    ((|ent_hit) || (gpr_we && (gpr_write_id == pend_query_id)));
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: expected writes are queued at stimulus time, a monitor checks the write port.
module tb_gpr_wb_arbiter;
  import gpr_pkg::*;

  localparam int NS = 2;
  localparam int IB = GPR_ID_BITS;
  localparam int VB = GPR_BITS;

  logic             clk;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*IB-1:0] src_id;
  logic [NS*VB-1:0] src_val;
  logic             gpr_we;
  logic [IB-1:0]    gpr_write_id;
  logic [VB-1:0]    gpr_write_val;
  logic [IB-1:0]    pend_query_id;
  logic             pend_hit;

  gpr_wb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_id        (src_id),
    .src_val       (src_val),
    .gpr_we        (gpr_we),
    .gpr_write_id  (gpr_write_id),
    .gpr_write_val (gpr_write_val),
    .pend_query_id (pend_query_id),
    .pend_hit      (pend_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_err = 0;
  wb_req_t  exp_q [$];
  wb_req_t  q0 [$];
  wb_req_t  q1 [$];
  wb_req_t  mon_exp;
  gpr_val_t gpr_mem [GPR_NUM];
  logic [NS-1:0] rdy_hist [64];
  bit       pend_en;
  bit       pend7_live;

  function automatic wb_req_t mk(input int id, input logic [31:0] val);
    wb_req_t r;
    r.id  = gpr_id_t'(id);
    r.val = val;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int s, input logic v, input wb_req_t r);
    src_valid[s]         = v;
    src_id[s*IB +: IB]   = r.id;
    src_val[s*VB +: VB]  = r.val;
  endtask

  // GPR file model: captures mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (gpr_we === 1'b1) gpr_mem[gpr_write_id] <= gpr_write_val;
  end

  // Write-port monitor.
  always @(negedge clk) begin
    if (gpr_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got id=%0d val=%h, expected no write", gpr_write_id, gpr_write_val);
      end else begin
        mon_exp = exp_q.pop_front();
        if (gpr_write_id !== mon_exp.id || gpr_write_val !== mon_exp.val) begin
          n_err++;
          $display("FAIL wb_data: got id=%0d val=%h, expected id=%0d val=%h",
                   gpr_write_id, gpr_write_val, mon_exp.id, mon_exp.val);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    src_valid = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_we", 32'(gpr_we), 32'd0);
    chk("rst_id", 32'(gpr_write_id), 32'd0);
    chk("rst_val", gpr_write_val, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives q0/q1 heads every cycle until both are accepted and all expected writes are seen.
  task automatic run_stream(input int budget);
    int cyc = 0;
    bit acc0, acc1;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      if (q0.size() > 0) set_src(0, 1'b1, q0[0]); else src_valid[0] = 1'b0;
      if (q1.size() > 0) set_src(1, 1'b1, q1[0]); else src_valid[1] = 1'b0;
      @(negedge clk);
      if (cyc < 64) rdy_hist[cyc] = src_ready;
      acc0 = src_valid[0] && src_ready[0];
      acc1 = src_valid[1] && src_ready[1];
      if (pend_en) begin
        pend_query_id = 5'd7;
        #1 chk("pend_q7", 32'(pend_hit), 32'(pend7_live));
        pend_query_id = 5'd8;
        #1 chk("pend_q8", 32'(pend_hit), 32'd0);
        if (gpr_we && gpr_write_id == 5'd7) pend7_live = 1'b0;
      end
      @(posedge clk);
      if (acc0) void'(q0.pop_front());
      if (acc1) begin
        if (q1[0].id == 5'd7) pend7_live = 1'b1;
        void'(q1.pop_front());
      end
      #1 cyc++;
    end
    src_valid = '0;
    n_vec++;
    if (cyc >= budget) begin
      n_err++;
      $display("FAIL stream_timeout: got %0d cycles, expected fewer than %0d", cyc, budget);
    end
  endtask

  initial begin
    rst           = 1'b1;
    src_valid     = '0;
    src_id        = '0;
    src_val       = '0;
    pend_query_id = '0;
    pend_en       = 1'b0;
    pend7_live    = 1'b0;
    for (int i = 0; i < 64; i++) rdy_hist[i] = '0;
    do_reset();

    // 1: single beat latency and GPR landing
    exp_q.push_back(mk(5, 32'hDEAD_BEEF));
    set_src(0, 1'b1, mk(5, 32'hDEAD_BEEF));
    @(negedge clk);
    chk("t1_ready", 32'(src_ready[0]), 32'd1);
    @(posedge clk);
    #1 src_valid = '0;
    @(negedge clk);
    chk("t1_we_early", 32'(gpr_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_we", 32'(gpr_we), 32'd1);
    chk("t1_id", 32'(gpr_write_id), 32'd5);
    @(posedge clk);
    @(negedge clk);
    chk("t1_gpr_x5", gpr_mem[5], 32'hDEAD_BEEF);
    @(posedge clk);
    #1;

    // 2/6: two saturated sources, full-FIFO pop/push without pass-through
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(1 + i, 32'h1000 + i));
      q1.push_back(mk(9 + i, 32'h2000 + i));
    end
`ifdef WB_ARB_RR_EN
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(1 + i, 32'h1000 + i));
      exp_q.push_back(mk(9 + i, 32'h2000 + i));
    end
`else
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(1 + i, 32'h1000 + i));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(9 + i, 32'h2000 + i));
`endif
    run_stream(200);
    chk("t2_rdy1_full_c2", 32'(rdy_hist[2][1]), 32'd0);
`ifdef WB_ARB_RR_EN
    chk("t6_rdy0_fullpop_c3", 32'(rdy_hist[3][0]), 32'd0);
    chk("t6_rdy1_c3", 32'(rdy_hist[3][1]), 32'd1);
`else
    chk("t6_rdy1_fullpop_c9", 32'(rdy_hist[9][1]), 32'd0);
    chk("t6_rdy1_c10", 32'(rdy_hist[10][1]), 32'd1);
`endif

    // 3: write to x0 is acknowledged and dropped
    pend_query_id = '0;
    set_src(1, 1'b1, mk(0, 32'd1234));
    @(negedge clk);
    chk("t3_ready", 32'(src_ready[1]), 32'd1);
    chk("t3_pend0", 32'(pend_hit), 32'd0);
    @(posedge clk);
    #1 src_valid = '0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_no_we", 32'(gpr_we), 32'd0);
      chk("t3_pend0_after", 32'(pend_hit), 32'd0);
      @(posedge clk);
    end
    #1;

    // 4: pending hit for id 7 queued behind contention
    do_reset();
    for (int i = 0; i < 3; i++) q0.push_back(mk(20 + i, 32'h3000 + i));
    q1.push_back(mk(7, 32'h0000_0077));
`ifdef WB_ARB_RR_EN
    exp_q.push_back(mk(20, 32'h3000));
    exp_q.push_back(mk(7, 32'h77));
    exp_q.push_back(mk(21, 32'h3001));
    exp_q.push_back(mk(22, 32'h3002));
`else
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(20 + i, 32'h3000 + i));
    exp_q.push_back(mk(7, 32'h77));
`endif
    pend_en = 1'b1;
    run_stream(100);
    pend_en = 1'b0;
    @(negedge clk);
    pend_query_id = 5'd7;
    #1 chk("t4_pend_q7_after", 32'(pend_hit), 32'd0);
    @(posedge clk);
    #1;

    // 5: reset mid-stream discards queued entries
    do_reset();
    exp_q.push_back(mk(11, 32'hA000));
    set_src(0, 1'b1, mk(11, 32'hA000));
    set_src(1, 1'b1, mk(12, 32'hB000));
    @(posedge clk);
    #1;
    set_src(0, 1'b1, mk(13, 32'hA001));
    set_src(1, 1'b1, mk(14, 32'hB001));
    @(negedge clk);
    chk("t5_ready_pre", 32'(src_ready), 32'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_ready_in_rst", 32'(src_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    src_valid = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_stale_we", 32'(gpr_we), 32'd0);
      pend_query_id = (i % 2 == 0) ? 5'd13 : 5'd12;
      #1 chk("t5_pend", 32'(pend_hit), 32'd0);
      pend_query_id = 5'd14;
      #1 chk("t5_pend14", 32'(pend_hit), 32'd0);
      @(posedge clk);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1);
  end
endmodule
